// File: rtl/mem_responder_if.sv
// Processor-bus bundle between the CVP14 core (master) and the memory responder (slave).
interface mem_responder_if;
  logic [15:0] Addr;
  logic        RD;
  logic        WR;
  logic        Burst;
  logic [15:0] DataIn;
  logic [15:0] DataOut;
  logic        Ready;
  logic        Busy;
  logic        Err;

  modport master (output Addr, RD, WR, Burst, DataIn,
                  input  DataOut, Ready, Busy, Err);
  modport slave  (input  Addr, RD, WR, Burst, DataIn,
                  output DataOut, Ready, Busy, Err);
endinterface

// File: rtl/mem_responder.sv
// Word-addressed memory responder: single/burst reads and writes with fixed wait states.
// All bus outputs are registered; they are computed from the next-state values so that
// the outputs of a cycle line up with the FSM state of that cycle.
module mem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2,
  parameter int BURST_LEN  = 16
) (
  input  logic           Clk1,
  input  logic           Reset,
  mem_responder_if.slave bus
);

  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int AW = DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, WAIT, XFER} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   base_q, base_d;
  logic            dir_q, dir_d;      // 1 = write
  logic            burst_q, burst_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [3:0]      wait_q, wait_d;
  logic            err_d;

  logic            ready_q, busy_q, err_q;
  logic [15:0]     dout_q;

  logic [15:0]     mem [2**AW];

  logic            last_beat;
  logic            free;
  logic            wr_en;
  logic [AW-1:0]   cur_addr;
  logic [AW-1:0]   nxt_addr;

  // Beat address wraps naturally at the top of memory via AW-bit addition.
  assign cur_addr  = base_q + AW'(beat_q);
  assign nxt_addr  = base_d + AW'(beat_d);
  assign last_beat = !burst_q || (beat_q == BW'(BURST_LEN - 1));
  // A new request may be taken in IDLE or at the edge that closes the final beat,
  // which makes Busy fall and the next request land on the same edge.
  assign free      = (state_q == IDLE) || ((state_q == XFER) && last_beat);
  assign wr_en     = (state_q == XFER) && dir_q && !Reset;

  // Next-state logic: wait countdown, beat advance, request capture and conflict detect.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    dir_d   = dir_q;
    burst_d = burst_q;
    beat_d  = beat_q;
    wait_d  = wait_q;
    err_d   = 1'b0;
    case (state_q)
      WAIT: begin
        if (wait_q == 4'd0) state_d = XFER;
        else                wait_d  = wait_q - 4'd1;
      end
      XFER: begin
        if (last_beat) state_d = IDLE;
        else           beat_d  = beat_q + 1'b1;
      end
      default: ;
    endcase
    if (free) begin
      if (bus.RD && bus.WR) begin
        err_d   = 1'b1;
        state_d = IDLE;
      end else if (bus.RD ^ bus.WR) begin
        base_d  = bus.Addr[AW-1:0];
        dir_d   = bus.WR;
        burst_d = bus.Burst;
        beat_d  = '0;
        wait_d  = 4'(LATENCY - 1);
        state_d = (LATENCY > 0) ? WAIT : XFER;
      end
    end
  end

  // Memory array: write beats commit at the edge closing their Ready cycle; never reset.
  always_ff @(posedge Clk1) begin
    if (wr_en) mem[cur_addr] <= bus.DataIn;
  end

  // State and registered outputs; read data forwards a same-edge write to the same word.
  always_ff @(posedge Clk1) begin
    if (Reset) begin
      state_q <= IDLE;
      base_q  <= '0;
      dir_q   <= 1'b0;
      burst_q <= 1'b0;
      beat_q  <= '0;
      wait_q  <= 4'd0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      dir_q   <= dir_d;
      burst_q <= burst_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
      ready_q <= (state_d == XFER);
      busy_q  <= (state_d != IDLE);
      err_q   <= err_d;
      if ((state_d == XFER) && !dir_d)
        dout_q <= (wr_en && (cur_addr == nxt_addr)) ? bus.DataIn : mem[nxt_addr];
      else
        dout_q <= '0;
    end
  end

  assign bus.DataOut = dout_q;
  assign bus.Ready   = ready_q;
  assign bus.Busy    = busy_q;
  assign bus.Err     = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: cycle table for single transfers, then burst, wrap,
// reset and zero-latency sequences.
module tb_mem_responder;

  logic Clk1;
  logic Reset;
  int   n_chk;
  int   n_fail;

  mem_responder_if bus0 ();
  mem_responder_if bus1 ();

  mem_responder #(.DEPTH_LOG2(10), .LATENCY(2), .BURST_LEN(16)) u_dut (
    .Clk1(Clk1), .Reset(Reset), .bus(bus0.slave));
  mem_responder #(.DEPTH_LOG2(10), .LATENCY(0), .BURST_LEN(16)) u_dut0 (
    .Clk1(Clk1), .Reset(Reset), .bus(bus1.slave));

  initial Clk1 = 1'b0;
  always #5 Clk1 = ~Clk1;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] din;
    logic        busy;
    logic        ready;
    logic        err;
    logic [15:0] dout;
  } vec_t;

  vec_t tv [13];

  task automatic tick();
    @(posedge Clk1);
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic wait_ready0(output int lat);
    lat = 0;
    while (!bus0.Ready && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  // Burst write d0+i on beat i; rst_beat >= 0 asserts Reset during that beat.
  task automatic burst_write(input logic [15:0] a, input logic [15:0] d0, input int rst_beat);
    int lat;
    bus0.WR = 1'b1; bus0.Addr = a; bus0.Burst = 1'b1;
    tick();
    bus0.WR = 1'b0;
    chk("bw_busy_start", 16'(bus0.Busy), 16'd1);
    wait_ready0(lat);
    chk("bw_latency", 16'(lat), 16'd2);
    for (int i = 0; i < 16; i++) begin
      chk("bw_ready", 16'(bus0.Ready), 16'd1);
      bus0.DataIn = d0 + 16'(i);
      if (i == rst_beat) begin
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("rst_busy", 16'(bus0.Busy), 16'd0);
        chk("rst_ready", 16'(bus0.Ready), 16'd0);
        chk("rst_err", 16'(bus0.Err), 16'd0);
        chk("rst_dout", bus0.DataOut, 16'h0000);
        return;
      end
      tick();
    end
    chk("bw_busy_end", 16'(bus0.Busy), 16'd0);
  endtask

  task automatic burst_read(input logic [15:0] a, input logic [15:0] d0);
    int busyc, nbeat, n;
    bus0.RD = 1'b1; bus0.Addr = a; bus0.Burst = 1'b1;
    tick();
    bus0.RD = 1'b0;
    busyc = 0; nbeat = 0; n = 0;
    while (bus0.Busy && n < 40) begin
      busyc++;
      if (bus0.Ready) begin
        chk("br_data", bus0.DataOut, d0 + 16'(nbeat));
        nbeat++;
      end
      tick();
      n++;
    end
    chk("br_busy_cycles", 16'(busyc), 16'd18);
    chk("br_beats", 16'(nbeat), 16'd16);
  endtask

  task automatic single_read(input string nm, input logic [15:0] a, input logic [15:0] exp);
    int lat;
    bus0.RD = 1'b1; bus0.Addr = a; bus0.Burst = 1'b0;
    tick();
    bus0.RD = 1'b0;
    wait_ready0(lat);
    chk(nm, bus0.DataOut, exp);
    tick();
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    bus0.RD = 0; bus0.WR = 0; bus0.Burst = 0; bus0.Addr = 0; bus0.DataIn = 0;
    bus1.RD = 0; bus1.WR = 0; bus1.Burst = 0; bus1.Addr = 0; bus1.DataIn = 0;
    Reset = 1'b1;
    tick(); tick();
    Reset = 1'b0;
    chk("reset_busy", 16'(bus0.Busy), 16'd0);
    chk("reset_ready", 16'(bus0.Ready), 16'd0);
    chk("reset_err", 16'(bus0.Err), 16'd0);
    chk("reset_dout", bus0.DataOut, 16'h0000);
    chk("reset_busy_l0", 16'(bus1.Busy), 16'd0);

    //          rd   wr   addr      din       busy ready err  dout
    tv[0]  = '{1'b0, 1'b1, 16'h0005, 16'hBEEF, 1'b1, 1'b0, 1'b0, 16'h0000};
    tv[1]  = '{1'b0, 1'b0, 16'h0005, 16'hBEEF, 1'b1, 1'b0, 1'b0, 16'h0000};
    tv[2]  = '{1'b0, 1'b0, 16'h0005, 16'hBEEF, 1'b1, 1'b1, 1'b0, 16'h0000};
    tv[3]  = '{1'b1, 1'b0, 16'h0005, 16'hBEEF, 1'b1, 1'b0, 1'b0, 16'h0000};
    tv[4]  = '{1'b0, 1'b0, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000};
    tv[5]  = '{1'b0, 1'b0, 16'h0005, 16'h0000, 1'b1, 1'b1, 1'b0, 16'hBEEF};
    tv[6]  = '{1'b0, 1'b0, 16'h0005, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000};
    tv[7]  = '{1'b1, 1'b1, 16'h0005, 16'hDEAD, 1'b0, 1'b0, 1'b1, 16'h0000};
    tv[8]  = '{1'b0, 1'b0, 16'h0005, 16'hDEAD, 1'b0, 1'b0, 1'b0, 16'h0000};
    tv[9]  = '{1'b1, 1'b0, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000};
    tv[10] = '{1'b0, 1'b1, 16'h0005, 16'h1234, 1'b1, 1'b0, 1'b0, 16'h0000};
    tv[11] = '{1'b0, 1'b0, 16'h0005, 16'h1234, 1'b1, 1'b1, 1'b0, 16'hBEEF};
    tv[12] = '{1'b0, 1'b0, 16'h0005, 16'h1234, 1'b0, 1'b0, 1'b0, 16'h0000};

    for (int i = 0; i < 13; i++) begin
      bus0.RD = tv[i].rd; bus0.WR = tv[i].wr; bus0.Addr = tv[i].addr;
      bus0.DataIn = tv[i].din; bus0.Burst = 1'b0;
      tick();
      chk($sformatf("tv%0d_busy", i), 16'(bus0.Busy), 16'(tv[i].busy));
      chk($sformatf("tv%0d_ready", i), 16'(bus0.Ready), 16'(tv[i].ready));
      chk($sformatf("tv%0d_err", i), 16'(bus0.Err), 16'(tv[i].err));
      chk($sformatf("tv%0d_dout", i), bus0.DataOut, tv[i].dout);
    end
    bus0.RD = 0; bus0.WR = 0;

    // Burst write then read back
    burst_write(16'h0040, 16'h1000, -1);
    burst_read(16'h0040, 16'h1000);

    // Wrap from top of memory to word 0; upper address bits ignored
    burst_write(16'h03F8, 16'h4000, -1);
    single_read("wrap_w0", 16'h0000, 16'h4008);
    single_read("wrap_alias", 16'hFC00, 16'h4008);
    single_read("wrap_top", 16'h03F8, 16'h4000);
    single_read("wrap_w7", 16'h0007, 16'h400F);

    // Reset mid-burst: prefill, then interrupt a second write at beat 5
    burst_write(16'h0100, 16'h3000, -1);
    burst_write(16'h0100, 16'h2000, 5);
    for (int i = 0; i < 16; i++)
      single_read($sformatf("rst_word%0d", i), 16'h0100 + 16'(i),
                  (i < 5) ? 16'h2000 + 16'(i) : 16'h3000 + 16'(i));

    // Reset beats a simultaneous request
    Reset = 1'b1; bus0.RD = 1'b1; bus0.Addr = 16'h0005;
    tick();
    Reset = 1'b0; bus0.RD = 1'b0;
    chk("rst_prio_busy", 16'(bus0.Busy), 16'd0);
    tick();
    chk("rst_prio_busy2", 16'(bus0.Busy), 16'd0);

    // Zero-latency build: back-to-back single transfers every cycle
    bus1.WR = 1'b1; bus1.Addr = 16'h0003; bus1.Burst = 1'b0; bus1.DataIn = 16'hA5A5;
    tick();
    chk("l0_w1_ready", 16'(bus1.Ready), 16'd1);
    chk("l0_w1_busy", 16'(bus1.Busy), 16'd1);
    bus1.Addr = 16'h0004;
    tick();
    chk("l0_w2_ready", 16'(bus1.Ready), 16'd1);
    bus1.WR = 1'b0; bus1.RD = 1'b1; bus1.DataIn = 16'h5A5A;
    tick();
    chk("l0_bypass_ready", 16'(bus1.Ready), 16'd1);
    chk("l0_bypass_dout", bus1.DataOut, 16'h5A5A);
    bus1.Addr = 16'h0003;
    tick();
    chk("l0_r2_dout", bus1.DataOut, 16'hA5A5);
    chk("l0_r2_busy", 16'(bus1.Busy), 16'd1);
    bus1.RD = 1'b0;
    tick();
    chk("l0_idle_busy", 16'(bus1.Busy), 16'd0);
    chk("l0_idle_dout", bus1.DataOut, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
